// File: rtl/write_string_sequencer_if.sv
// Memory write handshake between the string sequencer (master) and the data-write port (slave).
interface write_string_sequencer_if;
   logic        write_do;
   logic [31:0] write_address;
   logic [2:0]  write_length;
   logic [31:0] write_data;
   logic        write_done;

   modport master (
      output write_do, write_address, write_length, write_data,
      input  write_done
   );

   modport slave (
      input  write_do, write_address, write_length, write_data,
      output write_done
   );
endinterface

// File: rtl/write_string_sequencer.sv
// Write-stage per-iteration control FSM for STOS/MOVS/CMPS/SCAS/INS with REP loop and interrupt window.
// Optional build macro WRITE_STRING_SEQ_STATS_EN adds stat_iterations / stat_restarts counters.
module write_string_sequencer #(
   parameter int unsigned MIN_ITER_BEFORE_IRQ = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        is_store,
   input  logic        zf_terminated,
   input  logic        rep_active,
   input  logic [31:0] write_data_in,
   input  logic [2:0]  length_in,
   input  logic        interrupt_pending,
   input  logic        string_ignore,
   input  logic        string_finish,
   input  logic        string_zf_finish,
   input  logic        es_fault,
   input  logic [31:0] esi_final,
   input  logic [31:0] edi_final,
   input  logic [31:0] ecx_final,
   input  logic [31:0] es_linear,
   write_string_sequencer_if.master wr,
   output logic        reg_we,
   output logic [31:0] esi_out,
   output logic [31:0] edi_out,
   output logic [31:0] ecx_out,
   output logic        ecx_we,
   output logic        exc_gp,
   output logic        done,
   output logic        restart,
   output logic        busy
`ifdef WRITE_STRING_SEQ_STATS_EN
   ,
   output logic [31:0] stat_iterations,
   output logic [15:0] stat_restarts
`endif
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CHECK  = 2'd1,
      S_WRITE  = 2'd2,
      S_UPDATE = 2'd3
   } state_t;

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic [7:0]  cnt_d;
   logic        irq_allow_s;
   logic        store_q, zft_q, rep_q, fin_q;
   logic        write_do_q;
   logic [31:0] addr_q, data_q;
   logic [2:0]  len_q;
   logic [31:0] esi_q, edi_q, ecx_q;
   logic        reg_we_q, ecx_we_q, exc_gp_q, done_q, restart_q, busy_q;

   // Saturating iteration count and the interrupt-window qualification it feeds.
   always_comb begin
      cnt_d       = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      irq_allow_s = ({1'b0, cnt_d} >= 9'(MIN_ITER_BEFORE_IRQ));
   end

   // Sequencer FSM; all outputs are registered and pulses default low every cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 8'd0;
         store_q    <= 1'b0;
         zft_q      <= 1'b0;
         rep_q      <= 1'b0;
         fin_q      <= 1'b0;
         write_do_q <= 1'b0;
         addr_q     <= 32'd0;
         data_q     <= 32'd0;
         len_q      <= 3'd0;
         esi_q      <= 32'd0;
         edi_q      <= 32'd0;
         ecx_q      <= 32'd0;
         reg_we_q   <= 1'b0;
         ecx_we_q   <= 1'b0;
         exc_gp_q   <= 1'b0;
         done_q     <= 1'b0;
         restart_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         reg_we_q  <= 1'b0;
         ecx_we_q  <= 1'b0;
         exc_gp_q  <= 1'b0;
         done_q    <= 1'b0;
         restart_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_CHECK;
                  busy_q  <= 1'b1;
                  cnt_q   <= 8'd0;
                  store_q <= is_store;
                  zft_q   <= zf_terminated;
                  rep_q   <= rep_active;
               end else begin
                  busy_q  <= 1'b0;
               end
            end
            S_CHECK: begin
               if (string_ignore) begin
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else if (store_q && es_fault) begin
                  exc_gp_q <= 1'b1;
                  state_q  <= S_IDLE;
                  busy_q   <= 1'b0;
               end else begin
                  addr_q <= es_linear;
                  len_q  <= length_in;
                  data_q <= write_data_in;
                  esi_q  <= esi_final;
                  edi_q  <= edi_final;
                  ecx_q  <= ecx_final;
                  fin_q  <= zft_q ? string_zf_finish : string_finish;
                  if (store_q) begin
                     write_do_q <= 1'b1;
                     state_q    <= S_WRITE;
                  end else begin
                     reg_we_q <= 1'b1;
                     ecx_we_q <= rep_q;
                     state_q  <= S_UPDATE;
                  end
               end
            end
            S_WRITE: begin
               if (wr.write_done) begin
                  write_do_q <= 1'b0;
                  reg_we_q   <= 1'b1;
                  ecx_we_q   <= rep_q;
                  state_q    <= S_UPDATE;
               end else begin
                  write_do_q <= 1'b1;
               end
            end
            S_UPDATE: begin
               cnt_q <= cnt_d;
               // Termination beats the interrupt window; otherwise loop straight back to CHECK.
               if (!rep_q || fin_q) begin
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else if (interrupt_pending && irq_allow_s) begin
                  restart_q <= 1'b1;
                  state_q   <= S_IDLE;
                  busy_q    <= 1'b0;
               end else begin
                  state_q <= S_CHECK;
               end
            end
            default: begin
               state_q    <= S_IDLE;
               write_do_q <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign wr.write_do      = write_do_q;
   assign wr.write_address = addr_q;
   assign wr.write_length  = len_q;
   assign wr.write_data    = data_q;
   assign reg_we           = reg_we_q;
   assign esi_out          = esi_q;
   assign edi_out          = edi_q;
   assign ecx_out          = ecx_q;
   assign ecx_we           = ecx_we_q;
   assign exc_gp           = exc_gp_q;
   assign done             = done_q;
   assign restart          = restart_q;
   assign busy             = busy_q;

`ifdef WRITE_STRING_SEQ_STATS_EN
   logic [31:0] stat_iter_q;
   logic [15:0] stat_rst_q;

   // Free-running statistics; both counters wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_iter_q <= 32'd0;
         stat_rst_q  <= 16'd0;
      end else begin
         if (state_q == S_UPDATE) begin
            stat_iter_q <= stat_iter_q + 32'd1;
         end
         if (restart_q) begin
            stat_rst_q <= stat_rst_q + 16'd1;
         end
      end
   end

   assign stat_iterations = stat_iter_q;
   assign stat_restarts   = stat_rst_q;
`endif

endmodule

// File: tb/tb_write_string_sequencer.sv
// Directed bench: emulates the upstream evaluator and register file, scoreboards writes/write-backs/terminal events.
module tb_write_string_sequencer;
   localparam int unsigned MIN_IRQ = 1;
   localparam logic [31:0] ES_BASE = 32'h0001_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, is_store, zf_terminated, rep_active, interrupt_pending;
   logic [31:0] write_data_in, esi_final, edi_final, ecx_final, es_linear;
   logic [2:0]  length_in;
   logic        string_ignore, string_finish, string_zf_finish, es_fault;
   logic        reg_we, ecx_we, exc_gp, done, restart, busy;
   logic [31:0] esi_out, edi_out, ecx_out;
`ifdef WRITE_STRING_SEQ_STATS_EN
   logic [31:0] stat_iterations;
   logic [15:0] stat_restarts;
`endif

   write_string_sequencer_if wr ();

   write_string_sequencer #(.MIN_ITER_BEFORE_IRQ(MIN_IRQ)) dut (
      .clk(clk), .rst(rst), .start(start), .is_store(is_store), .zf_terminated(zf_terminated),
      .rep_active(rep_active), .write_data_in(write_data_in), .length_in(length_in),
      .interrupt_pending(interrupt_pending), .string_ignore(string_ignore),
      .string_finish(string_finish), .string_zf_finish(string_zf_finish), .es_fault(es_fault),
      .esi_final(esi_final), .edi_final(edi_final), .ecx_final(ecx_final), .es_linear(es_linear),
      .wr(wr), .reg_we(reg_we), .esi_out(esi_out), .edi_out(edi_out), .ecx_out(ecx_out),
      .ecx_we(ecx_we), .exc_gp(exc_gp), .done(done), .restart(restart), .busy(busy)
`ifdef WRITE_STRING_SEQ_STATS_EN
      , .stat_iterations(stat_iterations), .stat_restarts(stat_restarts)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Architectural registers and evaluator configuration
   logic [31:0] esi_r, edi_r, ecx_r, cfg_data;
   logic        cfg_uses_esi, cfg_fault, withhold;
   int          wb_cnt, cfg_zf_iter, cfg_irq_iter, wd_delay;
   logic [31:0] ecx_next_s;

   assign ecx_next_s        = rep_active ? ecx_r - 32'd1 : ecx_r;
   assign string_ignore     = rep_active && (ecx_r == 32'd0);
   assign string_finish     = rep_active && (ecx_next_s == 32'd0);
   assign string_zf_finish  = string_finish || ((cfg_zf_iter != 0) && (wb_cnt + 1 == cfg_zf_iter));
   assign es_fault          = cfg_fault;
   assign esi_final         = cfg_uses_esi ? esi_r + {29'd0, length_in} : esi_r;
   assign edi_final         = edi_r + {29'd0, length_in};
   assign ecx_final         = ecx_next_s;
   assign es_linear         = ES_BASE + edi_r;
   assign write_data_in     = cfg_data ^ edi_r;
   assign interrupt_pending = (cfg_irq_iter != 0) && (wb_cnt >= cfg_irq_iter);

   typedef struct { logic [31:0] a; logic [2:0] l; logic [31:0] d; } wr_t;
   typedef struct { logic [31:0] esi; logic [31:0] edi; logic [31:0] ecx; logic ecx_we; } wb_t;
   wr_t exp_wr[$];
   wb_t exp_wb[$];
   int  exp_term;   // 1 done, 2 restart, 3 #GP
   int  term_cnt;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Expected transaction list derived from the instruction-level rules
   task automatic build(input logic store, input logic rep, input logic zft, input logic [2:0] len,
                        input logic [31:0] ecx0);
      logic [31:0] esi0, edi0, lw, iu;
      esi0 = esi_r;
      edi0 = edi_r;
      lw   = {29'd0, len};
      exp_wr.delete();
      exp_wb.delete();
      term_cnt = 0;
      exp_term = 0;
      if (rep && ecx0 == 32'd0) begin
         exp_term = 1;
      end else if (store && cfg_fault) begin
         exp_term = 3;
      end else begin
         for (int i = 1; i <= 1000; i++) begin
            iu = 32'(i);
            if (store) exp_wr.push_back('{ES_BASE + edi0 + (iu - 32'd1) * lw, len, cfg_data ^ (edi0 + (iu - 32'd1) * lw)});
            exp_wb.push_back('{cfg_uses_esi ? esi0 + iu * lw : esi0, edi0 + iu * lw, rep ? ecx0 - iu : ecx0, rep});
            if (!rep || (ecx0 - iu == 32'd0) || (zft && i == cfg_zf_iter)) begin
               exp_term = 1;
               break;
            end
            if (cfg_irq_iter != 0 && i >= cfg_irq_iter && i >= int'(MIN_IRQ)) begin
               exp_term = 2;
               break;
            end
         end
      end
   endtask

   // Memory port: accepts a write wd_delay cycles after write_do rises unless withheld
   initial begin : responder
      int wcnt;
      wcnt = 0;
      wr.write_done = 1'b0;
      forever begin
         @(negedge clk);
         wr.write_done = 1'b0;
         if (wr.write_do && !withhold && !rst) begin
            if (wcnt >= wd_delay) begin
               wr.write_done = 1'b1;
               wcnt = 0;
            end else begin
               wcnt++;
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   // Per-cycle compare against the scoreboard; also retires write-backs into the register file
   initial begin : cmp
      logic prev_wd;
      wr_t  cur_wr;
      wb_t  cur_wb;
      int   kind;
      prev_wd = 1'b0;
      cur_wr = '{32'd0, 3'd0, 32'd0};
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_wd = 1'b0;
            continue;
         end
         if (wr.write_do) begin
            if (!prev_wd) begin
               check("write_expected", 32'(exp_wr.size() > 0), 32'd1);
               if (exp_wr.size() > 0) cur_wr = exp_wr.pop_front();
            end
            check("write_address", wr.write_address, cur_wr.a);
            check("write_length", {29'd0, wr.write_length}, {29'd0, cur_wr.l});
            check("write_data", wr.write_data, cur_wr.d);
         end
         prev_wd = wr.write_do;
         if (reg_we) begin
            check("wb_expected", 32'(exp_wb.size() > 0), 32'd1);
            check("wb_no_write_overlap", {31'd0, wr.write_do}, 32'd0);
            if (exp_wb.size() > 0) begin
               cur_wb = exp_wb.pop_front();
               check("esi_out", esi_out, cur_wb.esi);
               check("edi_out", edi_out, cur_wb.edi);
               check("ecx_we", {31'd0, ecx_we}, {31'd0, cur_wb.ecx_we});
               if (cur_wb.ecx_we) check("ecx_out", ecx_out, cur_wb.ecx);
            end
            esi_r = esi_out;
            edi_r = edi_out;
            if (ecx_we) ecx_r = ecx_out;
            wb_cnt++;
         end else begin
            check("ecx_we_qualified", {31'd0, ecx_we}, 32'd0);
         end
         if (done || restart || exc_gp) begin
            term_cnt++;
            kind = done ? 1 : (restart ? 2 : 3);
            check("term_onehot", 32'(done) + 32'(restart) + 32'(exc_gp), 32'd1);
            check("term_kind", 32'(kind), 32'(exp_term));
            check("term_not_busy", {31'd0, busy}, 32'd0);
         end
      end
   end

   task automatic run(input string nm, input logic store, input logic rep, input logic zft,
                      input logic uses_esi, input logic [2:0] len, input logic [31:0] ecx0,
                      input logic [31:0] esi0, input logic [31:0] edi0, input int zf_iter,
                      input int irq_iter, input logic fault, input int wdd, input logic [31:0] data,
                      input int exp_nwb, input int exp_lat, input logic poke_start);
      int lat;
      @(negedge clk);
      esi_r = esi0; edi_r = edi0; ecx_r = ecx0; wb_cnt = 0;
      cfg_uses_esi = uses_esi; cfg_zf_iter = zf_iter; cfg_irq_iter = irq_iter;
      cfg_fault = fault; wd_delay = wdd; cfg_data = data;
      is_store = store; rep_active = rep; zf_terminated = zft; length_in = len;
      build(store, rep, zft, len, ecx0);
      check({nm, "_model_wb_count"}, 32'(exp_wb.size()), 32'(exp_nwb));
      start = 1'b1;
      lat = 0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         start = 1'b0;
         lat++;
         if (poke_start && lat == 3) start = 1'b1;
         if (done || restart || exc_gp) break;
      end
      start = 1'b0;
      check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
      repeat (3) @(negedge clk);
      check({nm, "_writes_left"}, 32'(exp_wr.size()), 32'd0);
      check({nm, "_wbs_left"}, 32'(exp_wb.size()), 32'd0);
      check({nm, "_term_count"}, 32'(term_cnt), 32'd1);
      check({nm, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin : main
      int n;
      rst = 1'b1; start = 1'b0; is_store = 1'b0; zf_terminated = 1'b0; rep_active = 1'b0;
      length_in = 3'd1; esi_r = 32'd0; edi_r = 32'd0; ecx_r = 32'd0; cfg_data = 32'd0;
      cfg_uses_esi = 1'b0; cfg_fault = 1'b0; withhold = 1'b0; wb_cnt = 0;
      cfg_zf_iter = 0; cfg_irq_iter = 0; wd_delay = 0; exp_term = 0; term_cnt = 0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {24'd0, wr.write_do, reg_we, ecx_we, exc_gp, done, restart, busy, 1'b0}, 32'd0);
      check("reset_bus", wr.write_address | wr.write_data | esi_out | edi_out | ecx_out, 32'd0);
      rst = 1'b0;

      // REP STOSB ECX=3 with one wait cycle per write, plus an ignored start while busy
      run("rep_stosb", 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 32'd3, 32'h100, 32'h200, 0, 0, 1'b0, 1,
          32'hA5A5_0000, 3, 13, 1'b1);
      check("rep_stosb_ecx", ecx_r, 32'd0);
      check("rep_stosb_edi", edi_r, 32'h203);
      check("rep_stosb_esi", esi_r, 32'h100);

      // REP STOSW with ECX=0
      run("rep_stosw_ign", 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 32'd0, 32'h10, 32'h300, 0, 0, 1'b0, 0,
          32'h1111_2222, 0, 2, 1'b0);
      check("ign_edi", edi_r, 32'h300);

      // Non-REP STOSD with ES fault
      run("stosd_gp", 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 32'd5, 32'h20, 32'h400, 0, 0, 1'b1, 0,
          32'h3333_4444, 0, 2, 1'b0);
      check("gp_ecx", ecx_r, 32'd5);

      // REPE CMPSB ECX=10, ZF condition on iteration 2
      run("repe_cmpsb", 1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 32'd10, 32'h1000, 32'h2000, 2, 0, 1'b0, 0,
          32'd0, 2, 5, 1'b0);
      check("cmps_ecx", ecx_r, 32'd8);
      check("cmps_esi", esi_r, 32'h1002);

      // REP MOVSB ECX=100 broken by interrupt after the first iteration
      run("rep_movsb_irq", 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 32'd100, 32'h4000, 32'h5000, 0, 1, 1'b0, 0,
          32'h5A5A_5A5A, 1, 4, 1'b0);
      check("irq_ecx", ecx_r, 32'd99);
      check("irq_edi", edi_r, 32'h5001);

      // Reset while a write is outstanding
      @(negedge clk);
      cfg_irq_iter = 0; cfg_zf_iter = 0; cfg_fault = 1'b0; cfg_uses_esi = 1'b0; cfg_data = 32'hDEAD_0000;
      esi_r = 32'h0; edi_r = 32'h600; ecx_r = 32'd7; wb_cnt = 0; withhold = 1'b1;
      is_store = 1'b1; rep_active = 1'b0; zf_terminated = 1'b0; length_in = 3'd4;
      build(1'b1, 1'b0, 1'b0, 3'd4, 32'd7);
      start = 1'b1;
      n = 0;
      @(negedge clk);
      start = 1'b0;
      while (!wr.write_do && n < 20) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      check("rst_write_pending", {31'd0, wr.write_do}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_write_drop", {31'd0, wr.write_do}, 32'd0);
      check("rst_busy_drop", {29'd0, busy, reg_we, done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      withhold = 1'b0;
      exp_wr.delete();
      exp_wb.delete();
      repeat (4) @(negedge clk);
      check("rst_no_wb", 32'(wb_cnt), 32'd0);

      // Normal operation after the abort: REP STOSW ECX=2, immediate accept
      run("post_rst_stosw", 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 32'd2, 32'h0, 32'h700, 0, 0, 1'b0, 0,
          32'h0BAD_F00D, 2, 7, 1'b0);
      check("post_rst_edi", edi_r, 32'h704);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/write_string_sequencer.md
Name: write_string_sequencer

Overview:
- Per-iteration control FSM for string instructions (STOS/MOVS/CMPS/SCAS/INS) in the write stage.
- Sits directly downstream of the combinational write-stage string evaluator. Consumes its next-ESI/EDI/ECX values, ignore/finish/zf-finish flags, ES linear address and ES fault.
- Drives the memory write handshake, architectural register write-back, #GP signalling and REP loop termination, including the interrupt window between iterations.

Parameters:
MIN_ITER_BEFORE_IRQ, 1, completed iterations required before a pending interrupt may break a REP loop (1..255).

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse: string instruction enters write stage (ignored unless IDLE)
is_store  in  1  instruction writes ES:[EDI]
zf_terminated  in  1  CMPS/SCAS: REP termination uses zf-finish
rep_active  in  1  REP/REPE/REPNE prefix present
write_data_in  in  32  data to store this iteration
length_in  in  3  operand length 1/2/4
interrupt_pending  in  1  external interrupt waiting
string_ignore  in  1  from evaluator: REP with count 0
string_finish  in  1  from evaluator: count reaches 0 after this iteration
string_zf_finish  in  1  from evaluator: finish or ZF condition met
es_fault  in  1  from evaluator: ES limit/type fault
esi_final  in  32  next ESI
edi_final  in  32  next EDI
ecx_final  in  32  next ECX
es_linear  in  32  ES linear address of this iteration
write_do  out  1  memory write request
write_address  out  32  latched es_linear
write_length  out  3  latched length
write_data  out  32  latched data
write_done  in  1  memory write accepted (single-cycle pulse)
reg_we  out  1  one-cycle write-back strobe
esi_out  out  32  value written to ESI
edi_out  out  32  value written to EDI
ecx_out  out  32  value written to ECX (written only when rep_active)
ecx_we  out  1  ECX write enable, qualified with reg_we
exc_gp  out  1  one-cycle #GP(0) pulse
done  out  1  one-cycle: instruction complete, advance EIP
restart  out  1  one-cycle: loop broken for interrupt, EIP not advanced
busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, iteration counter 0. Reset mid-operation aborts immediately: write_do drops, no write-back.
- States: IDLE, CHECK, WRITE, UPDATE.
- IDLE + start -> CHECK. Iteration counter cleared.
- CHECK (1 cycle; evaluator inputs sampled this cycle):
  - string_ignore -> done=1, no reg_we, go to IDLE.
  - else is_store & es_fault -> exc_gp=1, no write, no reg_we, go to IDLE.
  - else latch es_linear/length_in/write_data_in/esi/edi/ecx_final; go to WRITE if is_store, else UPDATE.
- WRITE: write_do=1 with stable address/length/data until write_done. write_done in the first WRITE cycle is legal and is accepted; go to UPDATE the next cycle. write_do never re-asserts for the same iteration.
- UPDATE (1 cycle): reg_we=1 with latched values; ecx_we=rep_active; iteration counter +1, saturating at 255. Next state:
  - rep_active=0, or string_finish (zf_terminated=0), or string_zf_finish (zf_terminated=1) -> done=1, IDLE. Termination flags are latched in CHECK.
  - else interrupt_pending & counter+1 >= MIN_ITER_BEFORE_IRQ -> restart=1, IDLE.
  - else -> CHECK. The evaluator sees the updated registers in that CHECK cycle.
- done, restart and exc_gp are mutually exclusive and at most one per instruction.
- Minimum latency per non-store iteration is 2 cycles (CHECK + UPDATE); per store iteration it is 3 + write wait.
- start while busy is ignored.
- 16-bit address wrap is handled upstream; values are passed through unmodified.

Optional Feature:
WRITE_STRING_SEQ_STATS_EN
- Defined: adds output stat_iterations[31:0], a free-running count of UPDATE cycles since reset (wraps at 2^32), and stat_restarts[15:0], a count of restart pulses (wraps).
- Undefined: these ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- REP STOSB, ECX=3, es_fault=0, write_done 1 cycle after write_do -> 3 writes to es_linear values, 3 reg_we with ECX 2,1,0, done once, no restart.
- REP STOSW with string_ignore=1 (ECX=0) -> done 1 cycle after CHECK, write_do and reg_we never assert.
- Non-REP STOSD, es_fault=1 -> exc_gp pulse in CHECK, no write_do, no reg_we, busy clears next cycle.
- REPE CMPSB, zf_terminated=1, string_zf_finish=1 on iteration 2 with ECX=10 -> 2 reg_we, then done, no write_do.
- REP MOVSB, ECX=100, interrupt_pending raised during iteration 1, MIN_ITER_BEFORE_IRQ=1 -> restart after first UPDATE, ECX written 99, done not asserted.
- rst asserted while write_do=1 and write_done withheld -> write_do=0 immediately, no reg_we; a subsequent start works normally.
